// File: rtl/seq_cmp_pkg.sv
// Shared definitions for the multi-cycle comparator: FSM encoding and
// helpers that derive the pair count and index width from WIDTH.
package seq_cmp_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int pairs_of(input int width);
    return width / 2;
  endfunction

  // A single pair still needs a 1-bit index register.
  function automatic int idx_width(input int pairs);
    return (pairs <= 1) ? 1 : $clog2(pairs);
  endfunction

endpackage

// File: rtl/seq_cmp_if.sv
// Request/result bundle between the ALU control FSM (master) and the
// comparator (slave).
interface seq_cmp_if
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (
    output start, a, b,
    input  ready, busy, done, eq, gt, lt
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, eq, gt, lt
  );

endinterface

// File: rtl/seq_cmp_cmp2_slice.sv
// Combinational 2-bit compare slice; msb_signed makes the upper bit a
// two's-complement sign bit for the most significant pair.
module cmp2_slice
  import seq_cmp_pkg::*;
(
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic       msb_signed,
  output logic       p_eq,
  output logic       p_gt,
  output logic       p_lt
);

  logic [1:0] xk;
  logic [1:0] yk;

  // Inverting the sign bit maps two's-complement order onto unsigned order.
  assign xk = {x[1] ^ msb_signed, x[0]};
  assign yk = {y[1] ^ msb_signed, y[0]};

  assign p_eq = (xk == yk);
  assign p_gt = (xk > yk);
  assign p_lt = (xk < yk);

endmodule

// File: rtl/seq_cmp.sv
// Multi-cycle magnitude comparator: scans latched operands MSB-first,
// two bits per clock, stopping at the first differing pair.
module seq_cmp
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SIGNED = 0
) (
  input  logic      clk,
  input  logic      reset,
  seq_cmp_if.slave  bus
);

  localparam int                 PAIRS   = pairs_of(WIDTH);
  localparam int                 IDX_W   = idx_width(PAIRS);
  localparam logic [IDX_W-1:0]   IDX_TOP = IDX_W'(PAIRS - 1);
  localparam logic               SGN     = 1'(SIGNED != 0);

  generate
    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("seq_cmp: WIDTH must be even and >= 2");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  logic [1:0] pair_a;
  logic [1:0] pair_b;
  logic       msb_signed;
  logic       p_eq, p_gt, p_lt;

  assign pair_a     = a_q[{idx_q, 1'b0} +: 2];
  assign pair_b     = b_q[{idx_q, 1'b0} +: 2];
  assign msb_signed = SGN && (idx_q == IDX_TOP);

  cmp2_slice u_slice (
    .x          (pair_a),
    .y          (pair_b),
    .msb_signed (msb_signed),
    .p_eq       (p_eq),
    .p_gt       (p_gt),
    .p_lt       (p_lt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          idx_d   = IDX_TOP;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!p_eq) begin
          gt_d    = p_gt;
          lt_d    = p_lt;
          state_d = ST_DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.busy  = (state_q == ST_RUN);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.eq    = eq_q;
  assign bus.gt    = gt_q;
  assign bus.lt    = lt_q;

endmodule

// File: tb/tb_seq_cmp.sv
// Directed bench for seq_cmp: an unsigned and a signed instance are driven
// with identical stimulus and checked against hand-computed results.
module tb_seq_cmp;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_fail = 0;

  seq_cmp_if #(.WIDTH(W)) u_if ();
  seq_cmp_if #(.WIDTH(W)) s_if ();

  seq_cmp #(.WIDTH(W), .SIGNED(0)) u_dut (.clk(clk), .reset(reset), .bus(u_if.slave));
  seq_cmp #(.WIDTH(W), .SIGNED(1)) s_dut (.clk(clk), .reset(reset), .bus(s_if.slave));

  always #5 clk = ~clk;

  logic [2:0] u_res, s_res;
  assign u_res = {u_if.eq, u_if.gt, u_if.lt};
  assign s_res = {s_if.eq, s_if.gt, s_if.lt};

  localparam logic [2:0] R_EQ = 3'b100, R_GT = 3'b010, R_LT = 3'b001, R_NONE = 3'b000;

  // monitor state for one compare
  int         done_u, done_s, busy_u, busy_s;
  logic [2:0] got_u, got_s;
  logic       clr_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [W-1:0] av, input logic [W-1:0] bv);
    u_if.start = st; u_if.a = av; u_if.b = bv;
    s_if.start = st; s_if.a = av; s_if.b = bv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    done_u = 0; done_s = 0; busy_u = 0; busy_s = 0;
    got_u = R_NONE; got_s = R_NONE; clr_bad = 1'b0;
  endtask

  task automatic mon_sample(input int c);
    if (u_if.busy) begin
      busy_u++;
      if (u_res !== R_NONE) clr_bad = 1'b1;
    end
    if (s_if.busy) begin
      busy_s++;
      if (s_res !== R_NONE) clr_bad = 1'b1;
    end
    if (u_if.done && done_u == 0) begin done_u = c; got_u = u_res; end
    if (s_if.done && done_s == 0) begin done_s = c; got_s = s_res; end
  endtask

  task automatic run_cmp(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input int k_u, input logic [2:0] r_u,
                         input int k_s, input logic [2:0] r_s);
    drive(1'b1, av, bv);
    step();
    drive(1'b0, ~av, ~bv);
    mon_clear();
    for (int c = 1; c <= W/2 + 2; c++) begin
      mon_sample(c);
      step();
    end
    $display("cmp %s a=%02h b=%02h u:done@%0d res=%03b s:done@%0d res=%03b",
             tag, av, bv, done_u, got_u, done_s, got_s);
    check({tag, ".u_done_cycle"}, 32'(done_u), 32'(k_u + 1));
    check({tag, ".u_busy_cycles"}, 32'(busy_u), 32'(k_u));
    check({tag, ".u_result"}, 32'(got_u), 32'(r_u));
    check({tag, ".s_done_cycle"}, 32'(done_s), 32'(k_s + 1));
    check({tag, ".s_busy_cycles"}, 32'(busy_s), 32'(k_s));
    check({tag, ".s_result"}, 32'(got_s), 32'(r_s));
    check({tag, ".clear_while_run"}, 32'(clr_bad), 32'd0);
    check({tag, ".u_held"}, 32'(u_res), 32'(r_u));
    check({tag, ".s_held"}, 32'(s_res), 32'(r_s));
    check({tag, ".ready_after"}, 32'({u_if.ready, s_if.ready}), 32'b11);
  endtask

  initial begin
    drive(1'b0, '0, '0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    $display("reset ready=%b/%b busy=%b/%b res=%03b/%03b",
             u_if.ready, s_if.ready, u_if.busy, s_if.busy, u_res, s_res);
    check("rst.ready", 32'({u_if.ready, s_if.ready}), 32'b11);
    check("rst.busy",  32'({u_if.busy, s_if.busy}), 32'b00);
    check("rst.done",  32'({u_if.done, s_if.done}), 32'b00);
    check("rst.res",   32'({u_res, s_res}), 32'd0);

    //       tag        a      b      k_u res_u  k_s res_s
    run_cmp("a5_a5", 8'hA5, 8'hA5, 4, R_EQ, 4, R_EQ);
    run_cmp("c0_40", 8'hC0, 8'h40, 1, R_GT, 1, R_LT);
    run_cmp("12_13", 8'h12, 8'h13, 4, R_LT, 4, R_LT);
    run_cmp("ff_01", 8'hFF, 8'h01, 1, R_GT, 1, R_LT);
    run_cmp("80_7f", 8'h80, 8'h7F, 1, R_GT, 1, R_LT);
    run_cmp("3c_38", 8'h3C, 8'h38, 3, R_GT, 3, R_GT);
    run_cmp("90_b0", 8'h90, 8'hB0, 2, R_LT, 2, R_LT);

    // start held high, operands scrambled every cycle after acceptance
    drive(1'b1, 8'h00, 8'h01);
    step();
    mon_clear();
    for (int c = 1; c <= 5; c++) begin
      mon_sample(c);
      drive(1'b1, W'($urandom), W'($urandom));
      step();
    end
    $display("hold u:done@%0d res=%03b s:done@%0d res=%03b ready=%b busy=%b",
             done_u, got_u, done_s, got_s, u_if.ready, u_if.busy);
    check("hold.u_done_cycle", 32'(done_u), 32'd5);
    check("hold.u_result", 32'(got_u), 32'(R_LT));
    check("hold.s_done_cycle", 32'(done_s), 32'd5);
    check("hold.s_result", 32'(got_s), 32'(R_LT));
    check("hold.idle_c6", 32'({u_if.ready, u_if.busy, u_if.done}), 32'b100);
    step();
    check("hold.reaccept_c7", 32'({u_if.ready, u_if.busy, s_if.busy}), 32'b011);
    check("hold.cleared_c7", 32'({u_res, s_res}), 32'd0);
    drive(1'b0, '0, '0);
    reset = 1'b1;
    step();
    reset = 1'b0;

    // reset in the middle of a compare
    drive(1'b1, 8'h55, 8'h55);
    step();
    drive(1'b0, 8'h00, 8'hFF);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    $display("midrst ready=%b busy=%b res=%03b/%03b", u_if.ready, u_if.busy, u_res, s_res);
    check("midrst.state", 32'({u_if.ready, u_if.busy, s_if.ready, s_if.busy}), 32'b1010);
    check("midrst.res", 32'({u_res, s_res}), 32'd0);
    mon_clear();
    for (int c = 1; c <= 6; c++) begin
      mon_sample(c);
      step();
    end
    check("midrst.no_done", 32'(done_u + done_s), 32'd0);

    // start coincident with reset
    reset = 1'b1;
    drive(1'b1, 8'h01, 8'h02);
    step();
    $display("rststart ready=%b busy=%b", u_if.ready, u_if.busy);
    check("rststart.state", 32'({u_if.ready, u_if.busy, s_if.ready, s_if.busy}), 32'b1010);
    reset = 1'b0;
    drive(1'b0, '0, '0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_cmp.md
Name: seq_cmp

Overview:
- Multi-cycle N-bit magnitude/equality comparator for the ALU compare path.
- Extends the 2-bit equality slice into a full comparator that reports eq/gt/lt.
- Scans the two latched operands MSB-first, 2 bits per clock, and exits early on the first differing pair.
- Uses a start/ready/done handshake toward the ALU control FSM.

Parameters:
- WIDTH, 8: operand width in bits. Must be even and at least 2; elaborate-time error otherwise.
- SIGNED, 0: 0 = unsigned compare; 1 = two's-complement compare (only the MSB bit is interpreted as sign).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a compare; accepted only when ready=1.
- a  input  WIDTH  operand A; sampled on the accepting edge.
- b  input  WIDTH  operand B; sampled on the accepting edge.
- ready  output  1  high in IDLE; block can accept start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; result valid from this cycle.
- eq  output  1  A == B (registered, held until next accepted start).
- gt  output  1  A > B (registered, held).
- lt  output  1  A < B (registered, held).

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values: state=IDLE, ready=1, busy=0, done=0, eq=gt=lt=0, operand registers=0, idx=0.
- States:
  - IDLE to RUN: on start=1. Latch a and b, set idx=WIDTH/2-1, clear eq/gt/lt.
  - RUN: compare pair {A[2idx+1],A[2idx]} against {B[2idx+1],B[2idx]} using the slice.
    - Pair differs: set gt or lt, go to DONE.
    - Pair equal and idx==0: set eq=1, go to DONE.
    - Otherwise: idx decrements, stay in RUN.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Exactly one of eq/gt/lt is 1 after done; all three are 0 while RUN is in progress.
- Timing, with the accepting edge as cycle 0:
  - RUN occupies cycles 1..k, where k = number of pairs examined (1 ≤ k ≤ WIDTH/2).
  - done is high in cycle k+1.
  - Worst case: done at cycle WIDTH/2+1.
- Pair ordering (unsigned): numeric 2-bit compare.
- SIGNED=1: applies only to the top pair (idx=WIDTH/2-1).
  - If the MSBs differ, the operand with MSB=1 is smaller.
  - If the MSBs are equal, the low bit decides as unsigned.
  - All other pairs compare unsigned.
- start while not ready (RUN or DONE): ignored; operands are not resampled and no queueing occurs.
- start in the same cycle as reset: reset wins; the block stays in IDLE.
- reset during RUN or DONE: returns to IDLE next edge; done is not asserted; results are cleared.
- a/b changing after acceptance: no effect on the compare in progress.
- Back-to-back operation: start may be high in the cycle after done (block is IDLE). Minimum spacing between accepted starts is k+2 cycles.

Decomposition:
- Package seq_cmp_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - PAIRS = WIDTH/2 derivation;
  - index width = clog2(PAIRS), minimum 1.
- One combinational sub-module, cmp2_slice:
  - inputs: 2-bit x, 2-bit y, msb_signed;
  - outputs: p_eq, p_gt, p_lt;
  - instantiated once and fed by mux on idx.
- Top level holds the FSM, operand registers, idx counter, and result registers.

Test Plan:
- WIDTH=8, a=8'hA5, b=8'hA5 -> busy for 4 cycles; done at cycle 5 with eq=1, gt=0, lt=0.
- WIDTH=8, a=8'hC0, b=8'h40 -> top pair 11 vs 01; RUN lasts 1 cycle; done at cycle 2 with gt=1.
- WIDTH=8, a=8'h12, b=8'h13 -> full 4-pair scan; done at cycle 5 with lt=1, eq=0.
- SIGNED=1, a=8'hFF, b=8'h01 -> lt=1 after 1 RUN cycle. Same operands with SIGNED=0 -> gt=1.
- start=1 held continuously with a=8'h00, b=8'h01, and operands changed every cycle during RUN -> result is lt from the first-latched values; the next compare is accepted only in the cycle after done.
- reset pulsed at cycle 2 of an 8'h55 vs 8'h55 compare -> next cycle is IDLE with ready=1 and eq=gt=lt=0; no done pulse ever seen.
